// File: rtl/alu32_op_sequencer.sv
// alu32_op_sequencer: one-at-a-time request/response control for the ALU32 units.
// Registers operands onto the shared unit inputs, enables one unit, captures the result.
module alu32_op_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] In1,
    output logic [31:0] In2,
    output logic [5:0]  EnVec,
    input  logic [31:0] UnitOut,
    input  logic        UnitCarry,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Carry,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       arith;
    logic       bad;
    logic       legal;
    logic       accept;
    logic       capture;

    assign legal    = (Op <= 3'd5);
    assign accept   = (state == IDLE) && ReqValid;
    assign capture  = (state == DRIVE) && (cnt == 4'd1);
    assign ReqReady = (state == IDLE);
    assign RspValid = (state == RESP);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)   state_nxt = DRIVE;
            DRIVE:   if (capture)  state_nxt = RESP;
            RESP:    if (RspReady) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Illegal ops pass through DRIVE for one cycle with no unit enabled,
    // so their response appears with the same one-cycle latency as SETTLE=1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            In1    <= '0;
            In2    <= '0;
            EnVec  <= '0;
            Result <= '0;
            Zero   <= 1'b0;
            Carry  <= 1'b0;
            Err    <= 1'b0;
            cnt    <= '0;
            arith  <= 1'b0;
            bad    <= 1'b0;
        end else if (accept) begin
            In1   <= A;
            In2   <= B;
            arith <= Op[2];
            bad   <= !legal;
            if (legal) begin
                EnVec <= 6'd1 << Op;
                cnt   <= SETTLE_CNT;
            end else begin
                EnVec  <= '0;
                cnt    <= 4'd1;
                Result <= '0;
                Zero   <= 1'b0;
                Carry  <= 1'b0;
                Err    <= 1'b1;
            end
        end else if (state == DRIVE) begin
            cnt <= cnt - 4'd1;
            if (capture) begin
                EnVec <= '0;
                if (!bad) begin
                    Result <= UnitOut;
                    Zero   <= (UnitOut == 32'd0);
                    Carry  <= arith & UnitCarry;
                    Err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Bench for alu32_op_sequencer: four instances (SETTLE 1..4) share stimulus,
// each with a behavioural ALU32 unit model on its In1/In2/EnVec pins.
module tb_alu32_op_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        rsp_ready;
    logic [2:0]  op;
    logic [31:0] a, b;

    logic [N-1:0] req_ready, rsp_valid, zero, carry, err, ucarry;
    logic [31:0]  in1 [N];
    logic [31:0]  in2 [N];
    logic [31:0]  result [N];
    logic [31:0]  uout [N];
    logic [5:0]   envec [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        alu32_op_sequencer #(.SETTLE(g + 1)) dut (
            .Clk(clk), .Rst_n(rst_n),
            .ReqValid(req_valid), .ReqReady(req_ready[g]),
            .Op(op), .A(a), .B(b),
            .In1(in1[g]), .In2(in2[g]), .EnVec(envec[g]),
            .UnitOut(uout[g]), .UnitCarry(ucarry[g]),
            .RspValid(rsp_valid[g]), .RspReady(rsp_ready),
            .Result(result[g]), .Zero(zero[g]),
            .Carry(carry[g]), .Err(err[g])
        );
        assign uout[g] =
            ({32{envec[g][0]}} & (in1[g] & in2[g])) |
            ({32{envec[g][1]}} & (in1[g] | in2[g])) |
            ({32{envec[g][2]}} & (in1[g] ^ in2[g])) |
            ({32{envec[g][3]}} & ~(in1[g] | in2[g])) |
            ({32{envec[g][4]}} & 32'(in1[g] + in2[g])) |
            ({32{envec[g][5]}} & 32'(in1[g] - in2[g]));
        assign ucarry[g] =
            (envec[g][4] & (32'(in1[g] + in2[g]) < in1[g])) |
            (envec[g][5] & (in1[g] < in2[g]));
    end

    function automatic logic [31:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] x, y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return x + y;
            3'd5: return x - y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cy(input logic [2:0] o,
                                    input logic [31:0] x, y);
        logic [63:0] w;
        w = 64'(x) + 64'(y);
        if (o == 3'd4) return (w > 64'hFFFF_FFFF);
        if (o == 3'd5) return (x < y);
        return 1'b0;
    endfunction

    int          en_cnt [N];
    logic [5:0]  en_or [N];
    bit          oh_bad [N];
    bit          unstable [N];
    int          nresp [N];
    int          na [N];
    int          rk [N][2];
    int          dk [N][2];
    int          ak [N][2];
    logic [31:0] rres [N][2];
    logic        rz [N][2];
    logic        rc [N][2];
    logic        re [N][2];
    logic        prv [N];
    logic        prq [N];

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (t < 40 && !(req_ready == '1 && rsp_valid == '0)) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!(req_ready == '1 && rsp_valid == '0)) begin
            errors++;
            $display("FAIL %s idle_wait got rdy=%b vld=%b exp rdy=1111 vld=0000",
                     tag, req_ready, rsp_valid);
        end
    endtask

    // Runs one request (optionally a second held on ReqValid) and records
    // what every instance did; the calling test does the comparisons.
    task automatic exec_op(input logic [2:0] o, input logic [31:0] x, y,
                           input int hold, input bit keep,
                           input logic [2:0] o2, input logic [31:0] x2, y2);
        bit all2;
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0; en_or[i] = '0; oh_bad[i] = 0; unstable[i] = 0;
            nresp[i] = 0; na[i] = 0;
            rk[i][0] = -1; rk[i][1] = -1; dk[i][0] = -1; dk[i][1] = -1;
            ak[i][0] = -1; ak[i][1] = -1;
            prv[i] = rsp_valid[i]; prq[i] = req_ready[i];
        end
        op = o; a = x; b = y;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        for (int k = 0; k < hold + 20; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                if (keep) begin op = o2; a = x2; b = y2; end
                else req_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (envec[i] != 6'd0) begin
                    en_cnt[i]++;
                    en_or[i] |= envec[i];
                    if (!$onehot(envec[i])) oh_bad[i] = 1;
                end
                if (rsp_valid[i] && !prv[i]) begin
                    if (nresp[i] < 2) begin
                        rk[i][nresp[i]] = k;
                        rres[i][nresp[i]] = result[i];
                        rz[i][nresp[i]] = zero[i];
                        rc[i][nresp[i]] = carry[i];
                        re[i][nresp[i]] = err[i];
                        nresp[i]++;
                    end
                end else if (rsp_valid[i] && nresp[i] > 0) begin
                    if ({result[i], zero[i], carry[i], err[i]} !==
                        {rres[i][nresp[i]-1], rz[i][nresp[i]-1],
                         rc[i][nresp[i]-1], re[i][nresp[i]-1]})
                        unstable[i] = 1;
                end
                if (!rsp_valid[i] && prv[i] && nresp[i] > 0)
                    dk[i][nresp[i]-1] = k;
                if (prq[i] && !req_ready[i] && na[i] < 2) begin
                    ak[i][na[i]] = k;
                    na[i]++;
                end
                prv[i] = rsp_valid[i];
                prq[i] = req_ready[i];
            end
            all2 = 1;
            for (int i = 0; i < N; i++) if (na[i] < 2) all2 = 0;
            if (keep && all2) req_valid = 1'b0;
            rsp_ready = (k >= hold);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("exec");
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({in1[i], in2[i], envec[i], result[i]} !== 102'd0) begin
                errors++;
                $display("FAIL reset_data s%0d got %h %h %b %h exp zeros",
                         i + 1, in1[i], in2[i], envec[i], result[i]);
            end
            checks++;
            if ({zero[i], carry[i], err[i], rsp_valid[i], req_ready[i]} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_ctl s%0d got %b%b%b%b%b exp 00001", i + 1,
                         zero[i], carry[i], err[i], rsp_valid[i], req_ready[i]);
            end
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_and();
        exec_op(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (en_or[i] !== 6'b000001 || oh_bad[i]) begin
                errors++;
                $display("FAIL and_envec s%0d got %b exp 000001", i + 1, en_or[i]);
            end
            checks++;
            if (en_cnt[i] !== i + 1) begin
                errors++;
                $display("FAIL and_en_cycles s%0d got %0d exp %0d", i + 1, en_cnt[i], i + 1);
            end
            checks++;
            if (nresp[i] !== 1 || rk[i][0] !== i + 1) begin
                errors++;
                $display("FAIL and_latency s%0d got %0d (n=%0d) exp %0d",
                         i + 1, rk[i][0], nresp[i], i + 1);
            end
            checks++;
            if ({rres[i][0], rz[i][0], rc[i][0], re[i][0]} !== {32'hF000_F000, 3'b000}) begin
                errors++;
                $display("FAIL and_result s%0d got %h z%b c%b e%b exp f000f000 z0 c0 e0",
                         i + 1, rres[i][0], rz[i][0], rc[i][0], re[i][0]);
            end
        end
    endtask

    task automatic test_add();
        exec_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (en_or[i] !== 6'b010000 || en_cnt[i] !== i + 1 || oh_bad[i]) begin
                errors++;
                $display("FAIL add_envec s%0d got %b x%0d exp 010000 x%0d",
                         i + 1, en_or[i], en_cnt[i], i + 1);
            end
            checks++;
            if (rk[i][0] !== i + 1) begin
                errors++;
                $display("FAIL add_latency s%0d got %0d exp %0d", i + 1, rk[i][0], i + 1);
            end
            checks++;
            if ({rres[i][0], rz[i][0], rc[i][0], re[i][0]} !== {32'd0, 3'b110}) begin
                errors++;
                $display("FAIL add_result s%0d got %h z%b c%b e%b exp 00000000 z1 c1 e0",
                         i + 1, rres[i][0], rz[i][0], rc[i][0], re[i][0]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] o;
        for (int n = 0; n < 2; n++) begin
            o = (n == 0) ? 3'd6 : 3'd7;
            exec_op(o, 32'h1234_5678, $urandom(), 0, 0, 3'd0, 32'd0, 32'd0);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (en_cnt[i] !== 0) begin
                    errors++;
                    $display("FAIL ill_envec op%0d s%0d got %0d cycles exp 0", o, i + 1, en_cnt[i]);
                end
                checks++;
                if (nresp[i] !== 1 || rk[i][0] !== 1) begin
                    errors++;
                    $display("FAIL ill_latency op%0d s%0d got %0d exp 1", o, i + 1, rk[i][0]);
                end
                checks++;
                if ({rres[i][0], rz[i][0], rc[i][0], re[i][0]} !== {32'd0, 3'b001}) begin
                    errors++;
                    $display("FAIL ill_result op%0d s%0d got %h z%b c%b e%b exp 0 z0 c0 e1",
                             o, i + 1, rres[i][0], rz[i][0], rc[i][0], re[i][0]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] x, y, x2, y2;
        logic [2:0]  o2;
        x = $urandom(); y = $urandom();
        x2 = $urandom(); y2 = $urandom();
        o2 = 3'($urandom_range(0, 5));
        exec_op(3'd2, x, y, 5, 1, o2, x2, y2);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (unstable[i] || nresp[i] !== 2) begin
                errors++;
                $display("FAIL stall_hold s%0d got unstable=%0d n=%0d exp 0 2",
                         i + 1, unstable[i], nresp[i]);
            end
            checks++;
            if (rres[i][0] !== (x ^ y) || re[i][0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_res1 s%0d got %h exp %h", i + 1, rres[i][0], x ^ y);
            end
            checks++;
            if (dk[i][0] !== 6 || ak[i][1] !== dk[i][0] + 1) begin
                errors++;
                $display("FAIL stall_accept s%0d got hs=%0d acc=%0d exp 6 7",
                         i + 1, dk[i][0], ak[i][1]);
            end
            checks++;
            if (rres[i][1] !== ref_res(o2, x2, y2) || rc[i][1] !== ref_cy(o2, x2, y2) ||
                rk[i][1] !== ak[i][1] + i + 1) begin
                errors++;
                $display("FAIL stall_res2 s%0d got %h c%b @%0d exp %h c%b @%0d", i + 1,
                         rres[i][1], rc[i][1], rk[i][1], ref_res(o2, x2, y2),
                         ref_cy(o2, x2, y2), ak[i][1] + i + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] x, y;
        x = $urandom(); y = $urandom();
        op = 3'd5; a = x; b = y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({in1[i], in2[i], envec[i], rsp_valid[i], req_ready[i]} !== {70'd0, 2'b01}) begin
                errors++;
                $display("FAIL rst_mid s%0d got %h %h %b v%b r%b exp 0 0 0 v0 r1",
                         i + 1, in1[i], in2[i], envec[i], rsp_valid[i], req_ready[i]);
            end
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (rsp_valid !== '0 || req_ready !== '1) begin
                errors++;
                $display("FAIL rst_drop cyc%0d got vld=%b rdy=%b exp 0000 1111",
                         c, rsp_valid, req_ready);
            end
            @(posedge clk); #1;
        end
        exec_op(3'd5, y, x, 0, 0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rk[i][0] !== i + 1 || rres[i][0] !== y - x || rc[i][0] !== (y < x)) begin
                errors++;
                $display("FAIL rst_next s%0d got %h c%b @%0d exp %h c%b @%0d", i + 1,
                         rres[i][0], rc[i][0], rk[i][0], y - x, y < x, i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y, er;
        logic [5:0]  ee;
        int          hold, lat;
        bit          lg;
        for (int n = 0; n < 8; n++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom();
            y = ($urandom_range(0, 3) == 0) ? x : $urandom();
            hold = $urandom_range(0, 3);
            lg = (o <= 3'd5);
            er = ref_res(o, x, y);
            ee = lg ? (6'd1 << o) : 6'd0;
            exec_op(o, x, y, hold, 0, 3'd0, 32'd0, 32'd0);
            for (int i = 0; i < N; i++) begin
                lat = lg ? i + 1 : 1;
                checks++;
                if (en_or[i] !== ee || oh_bad[i] || en_cnt[i] !== (lg ? i + 1 : 0)) begin
                    errors++;
                    $display("FAIL rnd_envec op%0d s%0d got %b x%0d exp %b", o, i + 1,
                             en_or[i], en_cnt[i], ee);
                end
                checks++;
                if (nresp[i] !== 1 || rk[i][0] !== lat || unstable[i]) begin
                    errors++;
                    $display("FAIL rnd_timing op%0d s%0d got %0d exp %0d", o, i + 1, rk[i][0], lat);
                end
                checks++;
                if ({rres[i][0], rz[i][0], rc[i][0], re[i][0]} !==
                    {er, lg && er == 32'd0, ref_cy(o, x, y), !lg}) begin
                    errors++;
                    $display("FAIL rnd_result op%0d s%0d got %h z%b c%b e%b exp %h", o, i + 1,
                             rres[i][0], rz[i][0], rc[i][0], re[i][0], er);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  p_op [N];
        logic [31:0] p_a [N];
        logic [31:0] p_b [N];
        int          p_c [N];
        bit          p_v [N];
        int          last [N];
        int          nr [N];
        int          r, s;
        rsp_ready = 1'b1;
        op = 3'd3; a = 32'd0; b = 32'd0;
        req_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            p_op[i] = op; p_a[i] = a; p_b[i] = b; p_c[i] = 0;
            p_v[i] = req_ready[i]; last[i] = -1; nr[i] = 0;
        end
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                s = i + 1;
                checks++;
                if (envec[i] != 6'd0 && !$onehot(envec[i])) begin
                    errors++;
                    $display("FAIL b2b_onehot s%0d got %b exp one-hot", s, envec[i]);
                end
                if (rsp_valid[i]) begin
                    checks++;
                    if (!p_v[i] || result[i] !== ref_res(p_op[i], p_a[i], p_b[i]) ||
                        carry[i] !== ref_cy(p_op[i], p_a[i], p_b[i]) || err[i] !== 1'b0 ||
                        zero[i] !== (ref_res(p_op[i], p_a[i], p_b[i]) == 32'd0)) begin
                        errors++;
                        $display("FAIL b2b_result s%0d op%0d got %h c%b z%b exp %h c%b", s,
                                 p_op[i], result[i], carry[i], zero[i],
                                 ref_res(p_op[i], p_a[i], p_b[i]), ref_cy(p_op[i], p_a[i], p_b[i]));
                    end
                    checks++;
                    if (cyc - p_c[i] !== s + 1 || (last[i] >= 0 && cyc - last[i] !== s + 2)) begin
                        errors++;
                        $display("FAIL b2b_rate s%0d got lat=%0d gap=%0d exp %0d %0d", s,
                                 cyc - p_c[i] - 1, cyc - last[i], s, s + 2);
                    end
                    last[i] = cyc;
                    p_v[i] = 0;
                    nr[i]++;
                end
            end
            r = $urandom_range(0, 2);
            op = (r == 0) ? 3'd1 : (r == 1) ? 3'd3 : 3'd5;
            a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    p_op[i] = op; p_a[i] = a; p_b[i] = b; p_c[i] = cyc; p_v[i] = 1;
                end
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (nr[i] !== (60 - (i + 2)) / (i + 3) + 1) begin
                errors++;
                $display("FAIL b2b_count s%0d got %0d exp %0d", i + 1, nr[i],
                         (60 - (i + 2)) / (i + 3) + 1);
            end
        end
        wait_idle("b2b");
    endtask

    initial begin
        #300000;
        $display("FAIL timeout reached got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        #12;
        test_reset();
        test_and();
        test_add();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
